// File: rtl/quad_input_conditioner.sv
// Quadrature input conditioner.
// Synchronises the raw A/B/Z encoder pins and debounces them: a new level is
// accepted only after it has persisted for FILTER_LEN cycles. It flags single-bit
// (STEP) and double-bit (ILLEGAL) changes of the filtered A/B pair and keeps a
// saturating count of illegal transitions for firmware health monitoring.
module quad_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int ERR_W       = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             A_IN,
    input  logic             B_IN,
    input  logic             Z_IN,
    input  logic             ENABLE,
    input  logic             CLR_ERR,
    output logic             A_OUT,
    output logic             B_OUT,
    output logic             Z_OUT,
    output logic             STEP,
    output logic             ILLEGAL,
    output logic [ERR_W-1:0] ERR_COUNT,
    output logic             ERR_FLAG
);

    // Counter widths. FILTER_LEN=1 still gets a 1-bit counter that never leaves 0.
    localparam int CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int INIT_LEN = SYNC_STAGES + FILTER_LEN;
    localparam int INIT_W   = $clog2(INIT_LEN + 1);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FILTER_LEN - 1);
    localparam logic [INIT_W-1:0] INIT_ZERO = {INIT_W{1'b0}};
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_LEN - 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Channel bit order everywhere: [2]=A, [1]=B, [0]=Z.
    logic [2:0]       sync_r [SYNC_STAGES];
    logic [2:0]       sync_s;
    logic [CNT_W-1:0] cnt_r [3];
    logic [CNT_W-1:0] filt_cnt_s [3];
    logic [2:0]       filt_out_s;
    logic [2:0]       out_r;
    logic [1:0]       prev_r;
    logic [1:0]       ab_diff_s;
    logic             step_event_s;
    logic             illegal_event_s;
    logic             step_r;
    logic             illegal_r;
    logic [ERR_W-1:0] err_count_r;
    logic [ERR_W-1:0] err_count_s;
    logic             err_flag_r;
    logic             err_flag_s;
    logic [INIT_W-1:0] init_cnt_r;
    state_t           state_r;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chains run in every FSM state so levels are fresh on re-acquire.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 3'b000;
            end
        end else begin
            sync_r[0] <= {A_IN, B_IN, Z_IN};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Per-channel persistence filter: count cycles the synchronised level differs from the output.
    always_comb begin
        filt_out_s = out_r;
        for (int c = 0; c < 3; c++) begin
            filt_cnt_s[c] = cnt_r[c];
            if (sync_s[c] == out_r[c]) begin
                filt_cnt_s[c] = CNT_ZERO;
            end else if (cnt_r[c] == CNT_LAST) begin
                filt_out_s[c] = sync_s[c];
                filt_cnt_s[c] = CNT_ZERO;
            end else begin
                filt_cnt_s[c] = cnt_r[c] + CNT_W'(1);
            end
        end
    end

    // Classify the last A/B change; only meaningful while running.
    always_comb begin
        ab_diff_s       = prev_r ^ out_r[2:1];
        step_event_s    = 1'b0;
        illegal_event_s = 1'b0;
        if (state_r == ST_RUN) begin
            step_event_s    = (ab_diff_s == 2'b01) || (ab_diff_s == 2'b10);
            illegal_event_s = (ab_diff_s == 2'b11);
        end else begin
            step_event_s    = 1'b0;
            illegal_event_s = 1'b0;
        end
    end

    // Next error counter/flag: an illegal event beats a simultaneous clear.
    always_comb begin
        err_count_s = err_count_r;
        err_flag_s  = err_flag_r;
        if (illegal_event_s) begin
            err_flag_s = 1'b1;
            if (CLR_ERR) begin
                err_count_s = ERR_W'(1);
            end else if (&err_count_r) begin
                err_count_s = err_count_r;
            end else begin
                err_count_s = err_count_r + ERR_W'(1);
            end
        end else if (CLR_ERR) begin
            err_count_s = {ERR_W{1'b0}};
            err_flag_s  = 1'b0;
        end else begin
            err_count_s = err_count_r;
            err_flag_s  = err_flag_r;
        end
    end

    // Control FSM: acquire pin levels (INIT), filter (RUN), or freeze outputs (HOLD).
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r    <= ST_INIT;
            init_cnt_r <= INIT_ZERO;
            out_r      <= 3'b000;
            step_r     <= 1'b0;
            illegal_r  <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                cnt_r[c] <= CNT_ZERO;
            end
        end else begin
            case (state_r)
                ST_INIT: begin
                    out_r     <= sync_s;
                    step_r    <= 1'b0;
                    illegal_r <= 1'b0;
                    for (int c = 0; c < 3; c++) begin
                        cnt_r[c] <= CNT_ZERO;
                    end
                    if (!ENABLE) begin
                        state_r    <= ST_HOLD;
                        init_cnt_r <= INIT_ZERO;
                    end else if (init_cnt_r == INIT_LAST) begin
                        state_r    <= ST_RUN;
                        init_cnt_r <= INIT_ZERO;
                    end else begin
                        init_cnt_r <= init_cnt_r + INIT_W'(1);
                    end
                end
                ST_RUN: begin
                    out_r     <= filt_out_s;
                    step_r    <= step_event_s;
                    illegal_r <= illegal_event_s;
                    for (int c = 0; c < 3; c++) begin
                        cnt_r[c] <= filt_cnt_s[c];
                    end
                    if (!ENABLE) begin
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_HOLD: begin
                    step_r    <= 1'b0;
                    illegal_r <= 1'b0;
                    for (int c = 0; c < 3; c++) begin
                        cnt_r[c] <= CNT_ZERO;
                    end
                    if (ENABLE) begin
                        state_r    <= ST_INIT;
                        init_cnt_r <= INIT_ZERO;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r    <= ST_INIT;
                    init_cnt_r <= INIT_ZERO;
                    out_r      <= 3'b000;
                    step_r     <= 1'b0;
                    illegal_r  <= 1'b0;
                    for (int c = 0; c < 3; c++) begin
                        cnt_r[c] <= CNT_ZERO;
                    end
                end
            endcase
        end
    end

    // Previous A/B tracks the outputs in every state so leaving INIT/HOLD raises no event.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_r <= 2'b00;
        end else begin
            prev_r <= out_r[2:1];
        end
    end

    // Saturating illegal-transition counter and sticky flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            err_count_r <= {ERR_W{1'b0}};
            err_flag_r  <= 1'b0;
        end else begin
            err_count_r <= err_count_s;
            err_flag_r  <= err_flag_s;
        end
    end

    assign A_OUT     = out_r[2];
    assign B_OUT     = out_r[1];
    assign Z_OUT     = out_r[0];
    assign STEP      = step_r;
    assign ILLEGAL   = illegal_r;
    assign ERR_COUNT = err_count_r;
    assign ERR_FLAG  = err_flag_r;

endmodule

// File: tb/tb_quad_input_conditioner.sv
// Testbench for quad_input_conditioner: directed scenarios plus random pin
// activity, checked by a scoreboard fed from a pin-history reference model.
module tb_quad_input_conditioner;

    localparam int SYNC = 2;
    localparam int FLEN = 8;
    localparam int EW   = 2;
    localparam int EMAX = (1 << EW) - 1;
    localparam int M_INIT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          A_IN = 1'b0;
    logic          B_IN = 1'b0;
    logic          Z_IN = 1'b0;
    logic          ENABLE = 1'b1;
    logic          CLR_ERR = 1'b0;
    logic          A_OUT, B_OUT, Z_OUT, STEP, ILLEGAL, ERR_FLAG;
    logic [EW-1:0] ERR_COUNT;

    quad_input_conditioner #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLEN), .ERR_W(EW)) dut (
        .CLK(CLK), .RESET(RESET), .A_IN(A_IN), .B_IN(B_IN), .Z_IN(Z_IN),
        .ENABLE(ENABLE), .CLR_ERR(CLR_ERR), .A_OUT(A_OUT), .B_OUT(B_OUT),
        .Z_OUT(Z_OUT), .STEP(STEP), .ILLEGAL(ILLEGAL), .ERR_COUNT(ERR_COUNT),
        .ERR_FLAG(ERR_FLAG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int   cyc;
        logic a, b, z, step, ill;
        int   errc;
        logic errf;
    } rec_t;

    rec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;

    // Reference model state: pin history and output history since reset release.
    logic [2:0] pin_h[$];
    logic [2:0] o_h[$];
    int   n_m, mode, init_start, run_start, m_errc;
    logic m_errf;
    rec_t last_m;

    // Stimulus levels currently applied.
    logic a_v = 1'b0, b_v = 1'b0, z_v = 1'b0, en_v = 1'b1;

    function automatic logic [2:0] s_before(int k);
        return (k - SYNC >= 0) ? pin_h[k-SYNC] : 3'b000;
    endfunction

    function automatic logic [2:0] o_after(int k);
        return (k >= 0) ? o_h[k] : 3'b000;
    endfunction

    task automatic model_reset();
        pin_h.delete();
        o_h.delete();
        exp_q.delete();
        n_m = 0; mode = M_INIT; init_start = 0; run_start = 0;
        m_errc = 0; m_errf = 1'b0;
        last_m = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    endtask

    task automatic model_step(logic [2:0] pins, logic en, logic clr);
        logic [2:0] o_old, o_new, o1, o2, sk;
        logic [1:0] d;
        logic step, ill, flip;
        rec_t r;
        pin_h.push_back(pins);
        o_old = o_after(n_m - 1);
        o_new = o_old;
        step = 1'b0;
        ill = 1'b0;
        if (mode == M_INIT) begin
            o_new = s_before(n_m);
        end else if (mode == M_RUN) begin
            // A channel flips once its delayed pin has disagreed for FLEN running edges.
            for (int c = 0; c < 3; c++) begin
                flip = 1'b1;
                for (int k = n_m - FLEN + 1; k <= n_m; k++) begin
                    sk = s_before(k);
                    if (k < run_start || sk[c] == o_old[c]) flip = 1'b0;
                end
                if (flip) o_new[c] = ~o_old[c];
            end
            o1 = o_after(n_m - 1);
            o2 = o_after(n_m - 2);
            d = o1[2:1] ^ o2[2:1];
            step = (d == 2'b01) || (d == 2'b10);
            ill = (d == 2'b11);
        end
        if (ill) begin
            m_errf = 1'b1;
            m_errc = clr ? 1 : ((m_errc == EMAX) ? EMAX : m_errc + 1);
        end else if (clr) begin
            m_errc = 0;
            m_errf = 1'b0;
        end
        o_h.push_back(o_new);
        if (mode == M_INIT) begin
            if (!en) mode = M_HOLD;
            else if (n_m - init_start == SYNC + FLEN - 1) begin
                mode = M_RUN;
                run_start = n_m + 1;
            end
        end else if (mode == M_RUN) begin
            if (!en) mode = M_HOLD;
        end else begin
            if (en) begin
                mode = M_INIT;
                init_start = n_m + 1;
            end
        end
        r = '{edge_cnt, o_new[2], o_new[1], o_new[0], step, ill, m_errc, m_errf};
        if (step || ill || r.a != last_m.a || r.b != last_m.b || r.z != last_m.z ||
            r.errc != last_m.errc || r.errf != last_m.errf)
            exp_q.push_back(r);
        last_m = r;
        n_m++;
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle 1 time unit.
    task automatic tick(logic clr);
        A_IN = a_v; B_IN = b_v; Z_IN = z_v; ENABLE = en_v; CLR_ERR = clr;
        @(posedge CLK);
        edge_cnt++;
        if (!RESET) model_step({a_v, b_v, z_v}, en_v, clr);
        #1;
        CLR_ERR = 1'b0;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic release_reset();
        RESET = 1'b0;
        model_reset();
    endtask

    // Monitor: every visible DUT output event is matched against the next expected record.
    logic pa = 1'b0, pb = 1'b0, pz = 1'b0, pf = 1'b0;
    int   pc = 0;
    always @(negedge CLK) begin
        rec_t e;
        bit   stale;
        if (RESET) begin
            pa = 1'b0; pb = 1'b0; pz = 1'b0; pf = 1'b0; pc = 0;
        end else begin
            stale = 1'b1;
            while (stale && exp_q.size() > 0) begin
                e = exp_q[0];
                if (e.cyc < edge_cnt) begin
                    void'(exp_q.pop_front());
                    tests++;
                    fails++;
                    $display("FAIL missed_event: DUT showed nothing at cycle %0d, expected a=%0b b=%0b z=%0b step=%0b ill=%0b errc=%0d errf=%0b",
                             e.cyc, e.a, e.b, e.z, e.step, e.ill, e.errc, e.errf);
                end else begin
                    stale = 1'b0;
                end
            end
            if (A_OUT != pa || B_OUT != pb || Z_OUT != pz || ERR_FLAG != pf ||
                int'(ERR_COUNT) != pc || STEP || ILLEGAL) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event cycle %0d: got a=%0b b=%0b z=%0b step=%0b ill=%0b errc=%0d errf=%0b, none expected",
                             edge_cnt, A_OUT, B_OUT, Z_OUT, STEP, ILLEGAL, ERR_COUNT, ERR_FLAG);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != edge_cnt || e.a != A_OUT || e.b != B_OUT || e.z != Z_OUT ||
                        e.step != STEP || e.ill != ILLEGAL || e.errc != int'(ERR_COUNT) ||
                        e.errf != ERR_FLAG) begin
                        fails++;
                        $display("FAIL event: got cyc=%0d a=%0b b=%0b z=%0b step=%0b ill=%0b errc=%0d errf=%0b, expected cyc=%0d a=%0b b=%0b z=%0b step=%0b ill=%0b errc=%0d errf=%0b",
                                 edge_cnt, A_OUT, B_OUT, Z_OUT, STEP, ILLEGAL, ERR_COUNT, ERR_FLAG,
                                 e.cyc, e.a, e.b, e.z, e.step, e.ill, e.errc, e.errf);
                    end
                end
            end
            pa = A_OUT; pb = B_OUT; pz = Z_OUT; pf = ERR_FLAG; pc = int'(ERR_COUNT);
        end
    end

    initial begin
        model_reset();
        run(3);
        check("reset_outputs", int'({A_OUT, B_OUT, Z_OUT, STEP, ILLEGAL, ERR_FLAG}), 0);
        check("reset_err_count", int'(ERR_COUNT), 0);
        release_reset();

        // Clean A edge: exact latency, then a one-cycle STEP.
        run(20);
        a_v = 1'b1;
        run(9);
        check("t1_a_not_yet", int'(A_OUT), 0);
        run(1);
        check("t1_a_latency", int'(A_OUT), 1);
        check("t1_no_step_yet", int'(STEP), 0);
        run(1);
        check("t1_step_pulse", int'(STEP), 1);
        check("t1_no_illegal", int'(ILLEGAL), 0);
        run(1);
        check("t1_step_one_cycle", int'(STEP), 0);

        // Glitch rejection on B, then an accepted 8-cycle pulse.
        run(5);
        b_v = 1'b1; run(7);
        b_v = 1'b0; run(15);
        check("t2_glitch_rejected", int'(B_OUT), 0);
        b_v = 1'b1; run(8);
        b_v = 1'b0; run(2);
        check("t2_pulse_accepted", int'(B_OUT), 1);
        run(15);

        // Simultaneous A/B change -> ILLEGAL and error count.
        a_v = ~a_v; b_v = ~b_v;
        run(10);
        run(1);
        check("t3_illegal_pulse", int'(ILLEGAL), 1);
        check("t3_no_step", int'(STEP), 0);
        check("t3_err_count_1", int'(ERR_COUNT), 1);
        check("t3_err_flag", int'(ERR_FLAG), 1);
        run(1);
        check("t3_illegal_one_cycle", int'(ILLEGAL), 0);
        for (int i = 0; i < 2; i++) begin
            a_v = ~a_v; b_v = ~b_v; run(12);
        end
        check("t3_err_count_3", int'(ERR_COUNT), 3);

        // Saturation, clear racing an event, plain clear.
        for (int i = 0; i < 2; i++) begin
            a_v = ~a_v; b_v = ~b_v; run(12);
        end
        check("t4_saturated", int'(ERR_COUNT), EMAX);
        a_v = ~a_v; b_v = ~b_v;
        run(10);
        tick(1'b1);
        check("t4_clr_with_event_count", int'(ERR_COUNT), 1);
        check("t4_clr_with_event_flag", int'(ERR_FLAG), 1);
        run(3);
        tick(1'b1);
        check("t4_clr_count", int'(ERR_COUNT), 0);
        check("t4_clr_flag", int'(ERR_FLAG), 0);

        // Reset with pins high, then HOLD and re-acquire.
        run(3);
        RESET = 1'b1;
        a_v = 1'b1; b_v = 1'b1; z_v = 1'b0;
        run(2);
        release_reset();
        run(20);
        check("t5_init_a", int'(A_OUT), 1);
        check("t5_init_b", int'(B_OUT), 1);
        en_v = 1'b0; run(3);
        a_v = 1'b0; b_v = 1'b0; run(12);
        check("t5_hold_frozen", int'({A_OUT, B_OUT}), 3);
        en_v = 1'b1; run(25);
        check("t5_reacquired", int'({A_OUT, B_OUT}), 0);

        // Asynchronous reset in the middle of a filter count.
        a_v = 1'b1; b_v = 1'b1; run(12);
        run(3);
        a_v = 1'b0; run(7);
        check("t6_pre_reset_a", int'(A_OUT), 1);
        #1 RESET = 1'b1;
        #1;
        check("t6_async_outputs", int'({A_OUT, B_OUT, Z_OUT, STEP, ILLEGAL, ERR_FLAG}), 0);
        check("t6_async_err_count", int'(ERR_COUNT), 0);
        a_v = 1'b1; b_v = 1'b1;
        run(2);
        release_reset();
        run(2);
        check("t6_init_not_yet", int'(A_OUT), 0);
        run(1);
        check("t6_init_follows_pin", int'(A_OUT), 1);
        run(15);

        // Random pin activity, enable drops and clears.
        for (int seg = 0; seg < 80; seg++) begin
            int r;
            int len;
            r = $urandom_range(0, 9);
            if (r < 2) begin a_v = ~a_v; b_v = ~b_v; end
            else if (r < 5) a_v = ~a_v;
            else if (r < 7) b_v = ~b_v;
            else if (r == 7) z_v = ~z_v;
            else if (r == 8) en_v = ~en_v;
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) tick($urandom_range(0, 7) == 0);
        end
        en_v = 1'b1;
        run(40);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
